hqm_rcfwl_gclk_psocsyncdist_deskew: RTL and testbench

//  Parametrised successor of the PSOC sync fan-out. Distributes sync_in to NUM_OF_OUTPUTS leaves via a
//  NUM_OF_RPTRS-stage repeater pipeline, then adds a programmable per-output deskew delay (0..MAX_SKEW).

---
 rtl/hqm_rcfwl_gclk_psocsyncdist_deskew.sv | 175 +++++++++++++++++
 tb/tb_hqm_rcfwl_gclk_psocsyncdist_deskew.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hqm_rcfwl_gclk_psocsyncdist_deskew.sv
// PSOC sync fan-out: shared repeater pipeline, per-output deskew taps and a sync period lock monitor.
// Optional HQM_PSOCSYNCDIST_LOCKED_GATE_EN: sync_out held low until the monitor reports lock.
module hqm_rcfwl_gclk_psocsyncdist_deskew #(
    parameter int unsigned NUM_OF_OUTPUTS = 4,
    parameter int unsigned NUM_OF_RPTRS   = 2,
    parameter int unsigned MAX_SKEW       = 7,
    parameter int unsigned SKEW_W         = $clog2(MAX_SKEW + 1),
    parameter int unsigned PERIOD_W       = 8,
    parameter int unsigned LOCK_CNT       = 3
) (
    input  logic                             adop_postclk_free,
    input  logic                             powergood_rst_b,
    input  logic                             sync_in,
    input  logic [NUM_OF_OUTPUTS*SKEW_W-1:0] skew_cfg,
    input  logic                             cfg_load,
    input  logic [PERIOD_W-1:0]              period_cfg,
    output logic [NUM_OF_OUTPUTS-1:0]        sync_out,
    output logic                             cfg_pending,
    output logic                             sync_locked,
    output logic                             sync_err
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {StIdle, StAcquire, StLocked} mon_state_e;

    logic [NUM_OF_RPTRS-1:0] rptr_q, rptr_d;
    logic [MAX_SKEW-1:0]     dly_q, dly_d;
    logic                    base;

    assign base = rptr_q[NUM_OF_RPTRS-1];

    // Every output taps the same base-fed delay line, so one line serves them all.
    always_comb begin
        rptr_d    = '0;
        rptr_d[0] = sync_in;
        for (int k = 1; k < NUM_OF_RPTRS; k++) rptr_d[k] = rptr_q[k-1];
        dly_d    = '0;
        dly_d[0] = base;
        for (int k = 1; k < MAX_SKEW; k++) dly_d[k] = dly_q[k-1];
    end

    always_ff @(posedge adop_postclk_free or negedge powergood_rst_b) begin
        if (!powergood_rst_b) begin
            rptr_q <= '0;
            dly_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            dly_q  <= dly_d;
        end
    end

    logic [NUM_OF_OUTPUTS-1:0][SKEW_W-1:0] shadow_q, shadow_d, skew_q;
    logic                                  pending_q;
    logic                                  pipe_empty;
    logic                                  apply_cfg;

    function automatic logic [SKEW_W-1:0] clamp_skew(input logic [SKEW_W-1:0] s);
        if (32'(s) > MAX_SKEW) return SKEW_W'(MAX_SKEW);
        return s;
    endfunction

    always_comb begin
        shadow_d = shadow_q;
        if (cfg_load) begin
            for (int i = 0; i < NUM_OF_OUTPUTS; i++) begin
                shadow_d[i] = clamp_skew(skew_cfg[i*SKEW_W +: SKEW_W]);
            end
        end
    end

    // Swapping skew only with nothing in flight keeps every pulse intact and in order.
    assign pipe_empty = (rptr_q == '0) && (dly_q == '0);
    assign apply_cfg  = pending_q && pipe_empty;

    always_ff @(posedge adop_postclk_free or negedge powergood_rst_b) begin
        if (!powergood_rst_b) begin
            shadow_q  <= '0;
            skew_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (apply_cfg) skew_q <= shadow_q;
            if (cfg_load) begin
                pending_q <= 1'b1;
            end else if (apply_cfg) begin
                pending_q <= 1'b0;
            end
        end
    end

    logic [NUM_OF_OUTPUTS-1:0] tap;

    always_comb begin
        tap = '0;
        for (int i = 0; i < NUM_OF_OUTPUTS; i++) begin
            if (skew_q[i] == '0) tap[i] = base;
            else                 tap[i] = dly_q[skew_q[i] - SKEW_W'(1)];
        end
    end

    mon_state_e          state_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [GOOD_W-1:0]   good_q;
    logic                locked_q;
    logic                err_q;
    logic                on_period;
    logic                late;

    assign on_period = (cnt_q == period_cfg);
    assign late      = (cnt_q > period_cfg);

    always_ff @(posedge adop_postclk_free or negedge powergood_rst_b) begin
        if (!powergood_rst_b) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (base) begin
                cnt_q <= PERIOD_W'(1);
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (period_cfg == '0) begin
                state_q  <= StIdle;
                good_q   <= '0;
                locked_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (base) begin
                            state_q <= StAcquire;
                            good_q  <= '0;
                        end
                    end
                    StAcquire: begin
                        if (base) begin
                            if (!on_period) begin
                                good_q <= '0;
                            end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                                good_q   <= '0;
                            end else begin
                                good_q <= good_q + 1'b1;
                            end
                        end
                    end
                    StLocked: begin
                        if ((base && !on_period) || (!base && late)) begin
                            state_q  <= StAcquire;
                            locked_q <= 1'b0;
                            err_q    <= 1'b1;
                            good_q   <= '0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign cfg_pending = pending_q;
    assign sync_locked = locked_q;
    assign sync_err    = err_q;

`ifdef HQM_PSOCSYNCDIST_LOCKED_GATE_EN
    assign sync_out = tap & {NUM_OF_OUTPUTS{locked_q}};
`else
    assign sync_out = tap;
`endif

endmodule

// File: tb/tb_hqm_rcfwl_gclk_psocsyncdist_deskew.sv
// Bench for the PSOC sync deskew distributor: history-based reference model plus directed literal checks.
module tb_hqm_rcfwl_gclk_psocsyncdist_deskew;

    localparam int NOUT = 4;
    localparam int NRPT = 2;
    localparam int MAXS = 7;
    localparam int SW   = 3;
    localparam int PW   = 8;
    localparam int LCNT = 3;
    localparam int HMAX = 16384;

`ifdef HQM_PSOCSYNCDIST_LOCKED_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               sync_in = 1'b0;
    logic               cfg_load = 1'b0;
    logic [NOUT*SW-1:0] skew_cfg = '0;
    logic [PW-1:0]      period_cfg = '0;
    logic [NOUT-1:0]    sync_out;
    logic               cfg_pending;
    logic               sync_locked;
    logic               sync_err;

    always #5 clk = ~clk;

    hqm_rcfwl_gclk_psocsyncdist_deskew #(
        .NUM_OF_OUTPUTS (NOUT),
        .NUM_OF_RPTRS   (NRPT),
        .MAX_SKEW       (MAXS),
        .SKEW_W         (SW),
        .PERIOD_W       (PW),
        .LOCK_CNT       (LCNT)
    ) dut (
        .adop_postclk_free (clk),
        .powergood_rst_b   (rst_n),
        .sync_in           (sync_in),
        .skew_cfg          (skew_cfg),
        .cfg_load          (cfg_load),
        .period_cfg        (period_cfg),
        .sync_out          (sync_out),
        .cfg_pending       (cfg_pending),
        .sync_locked       (sync_locked),
        .sync_err          (sync_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: sync_in history indexed by cycle number, plus monitor/config state.
    bit  hist [HMAX];
    int  cyc = 0;
    int  valid_from = 1 << 30;
    int  ref_cyc = 0;
    bit  need_start = 1'b1;
    int  m_active [NOUT] = '{default: 0};
    int  m_shadow [NOUT] = '{default: 0};
    bit  m_pend = 1'b0;
    bit  m_locked = 1'b0;
    bit  m_err = 1'b0;
    int  m_state = 0;  // 0 idle, 1 acquire, 2 locked
    int  m_good = 0;
    logic [NOUT-1:0] exp_out;

    function automatic bit past(input int k);
        if (k < 0 || k < valid_from || k >= HMAX) return 1'b0;
        return hist[k];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NOUT; i++) begin
            m_active[i] = 0;
            m_shadow[i] = 0;
        end
        m_pend = 0; m_locked = 0; m_err = 0; m_state = 0; m_good = 0;
        valid_from = 1 << 30;
        need_start = 1'b1;
    endtask

    task automatic model_step(input int c);
        int cnt;
        int f;
        bit base;
        bit busy;
        bit apply;
        if (need_start) begin
            valid_from = c;
            ref_cyc    = c;
            need_start = 1'b0;
        end
        if (c < HMAX) hist[c] = sync_in;
        base = past(c - NRPT);
        cnt  = c - ref_cyc;
        if (cnt > (1 << PW) - 1) cnt = (1 << PW) - 1;
        if (period_cfg == 0) begin
            m_state = 0; m_locked = 0; m_good = 0;
        end else begin
            case (m_state)
                0: if (base) begin m_state = 1; m_good = 0; end
                1: if (base) begin
                    if (cnt == int'(period_cfg)) begin
                        m_good++;
                        if (m_good == LCNT) begin m_state = 2; m_locked = 1; m_good = 0; end
                    end else begin
                        m_good = 0;
                    end
                end
                default: if ((base && cnt != int'(period_cfg)) || (!base && cnt > int'(period_cfg))) begin
                    m_err = 1; m_locked = 0; m_state = 1; m_good = 0;
                end
            endcase
        end
        if (base) ref_cyc = c;
        busy = 1'b0;
        for (int k = 1; k <= NRPT + MAXS; k++) busy |= past(c - k);
        apply = m_pend && !busy;
        if (apply) for (int i = 0; i < NOUT; i++) m_active[i] = m_shadow[i];
        if (cfg_load) begin
            for (int i = 0; i < NOUT; i++) begin
                f = int'(skew_cfg[i*SW +: SW]);
                m_shadow[i] = (f > MAXS) ? MAXS : f;
            end
            m_pend = 1'b1;
        end else if (apply) begin
            m_pend = 1'b0;
        end
    endtask

    initial forever begin
        @(negedge rst_n);
        model_reset();
    end

    initial forever begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(cyc);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        exp_out = '0;
        for (int i = 0; i < NOUT; i++) exp_out[i] = past(cyc - NRPT - m_active[i]);
        if (GATED && !m_locked) exp_out = '0;
        chk("cyc_sync_out", int'(sync_out), int'(exp_out));
        chk("cyc_cfg_pending", int'(cfg_pending), int'(m_pend));
        chk("cyc_sync_locked", int'(sync_locked), int'(m_locked));
        chk("cyc_sync_err", int'(sync_err), int'(m_err));
    end

    task automatic cyc_adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int gap);
        sync_in = 1'b1;
        cyc_adv(1);
        sync_in = 1'b0;
        cyc_adv(gap - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    int rise [NOUT];
    int lat_exp [NOUT] = '{3, 9, 2, 5};
    int per;
    int ph;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sync_out", int'(sync_out), 0);
        chk("rst_cfg_pending", int'(cfg_pending), 0);
        chk("rst_sync_locked", int'(sync_locked), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        rst_n = 1'b1;
        cyc_adv(2);

        // Latency with skew {3,0,7,1}; load on an empty pipe pends for exactly one cycle.
        skew_cfg = {3'd3, 3'd0, 3'd7, 3'd1};
        cfg_load = 1'b1;
        cyc_adv(1);
        cfg_load = 1'b0;
        @(negedge clk);
        chk("load_empty_pend", int'(cfg_pending), 1);
        cyc_adv(1);
        @(negedge clk);
        chk("load_empty_done", int'(cfg_pending), 0);
        cyc_adv(2);
        sync_in = 1'b1;
        for (int b = 0; b < NOUT; b++) rise[b] = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc_adv(1);
            sync_in = 1'b0;
            @(negedge clk);
            for (int b = 0; b < NOUT; b++) if (sync_out[b] && rise[b] == 0) rise[b] = k;
        end
        for (int b = 0; b < NOUT; b++) chk($sformatf("latency_out%0d", b), rise[b], GATED ? 0 : lat_exp[b]);

        // Deferred load: pulse in flight under old skew, new all-zero skew waits.
        cyc_adv(1);
        sync_in = 1'b1;
        cyc_adv(1);
        sync_in = 1'b0;
        cyc_adv(2);
        skew_cfg = '0;
        cfg_load = 1'b1;
        cyc_adv(1);
        cfg_load = 1'b0;
        @(negedge clk);
        chk("defer_pend_early", int'(cfg_pending), 1);
        cyc_adv(5);
        @(negedge clk);
        chk("defer_old_skew_out1", int'(sync_out[1]), GATED ? 0 : 1);
        cyc_adv(1);
        @(negedge clk);
        chk("defer_pend_last", int'(cfg_pending), 1);
        cyc_adv(1);
        @(negedge clk);
        chk("defer_applied", int'(cfg_pending), 0);

        // Lock on period 16, then early pulse at 15.
        period_cfg = 8'd16;
        cyc_adv(2);
        repeat (3) send(16);
        sync_in = 1'b1;
        cyc_adv(1);
        sync_in = 1'b0;
        cyc_adv(1);
        @(negedge clk);
        chk("lock_not_yet", int'(sync_locked), 0);
        cyc_adv(1);
        @(negedge clk);
        chk("lock_after_4th", int'(sync_locked), 1);
        cyc_adv(12);
        sync_in = 1'b1;
        cyc_adv(1);
        sync_in = 1'b0;
        cyc_adv(1);
        @(negedge clk);
        chk("early_err_not_yet", int'(sync_err), 0);
        cyc_adv(1);
        @(negedge clk);
        chk("early_err", int'(sync_err), 1);
        chk("early_unlock", int'(sync_locked), 0);

        // Asynchronous reset with a pulse at base.
        cyc_adv(3);
        sync_in = 1'b1;
        cyc_adv(1);
        sync_in = 1'b0;
        cyc_adv(1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", int'(sync_out), 0);
        chk("async_rst_err", int'(sync_err), 0);
        chk("async_rst_locked", int'(sync_locked), 0);
        cyc_adv(3);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_adv(1);

        // Lock again, then miss a pulse.
        repeat (4) send(16);
        cyc_adv(3);
        @(negedge clk);
        chk("miss_still_locked", int'(sync_locked), 1);
        chk("miss_err_not_yet", int'(sync_err), 0);
        cyc_adv(1);
        @(negedge clk);
        chk("miss_err", int'(sync_err), 1);
        chk("miss_unlock", int'(sync_locked), 0);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 6; seg++) begin
            if (seg == 3) begin
                rst_n = 1'b0;
                cyc_adv(2);
                @(negedge clk);
                rst_n = 1'b1;
                cyc_adv(1);
            end
            per = $urandom_range(3, 20);
            period_cfg = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'(per);
            ph = 0;
            repeat (400) begin
                sync_in  = (ph == 0) || ($urandom_range(0, 70) == 0);
                cfg_load = ($urandom_range(0, 25) == 0);
                skew_cfg = 12'($urandom());
                if ($urandom_range(0, 150) == 0) period_cfg = 8'($urandom_range(0, 20));
                ph = ($urandom_range(0, 90) == 0) ? 0 : (ph + 1) % per;
                cyc_adv(1);
            end
        end
        sync_in  = 1'b0;
        cfg_load = 1'b0;
        cyc_adv(12);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
